icache_sa: RTL and testbench

Parametrised set-associative instruction cache between the IF stage and the instruction memory port. One 32-bit instruction per request: registered response on a hit, a single line-wide memory read on a miss. Adds configurable ways, sets and line size, round-robin replacement with an invalid-way preference, a refill that always completes after a pipeline kill, and whole-cache invalidation for `fence.i`.

---
 rtl/icache_sa_if.sv | 27 ++
 rtl/icache_sa.sv | 185 ++++++++++++++++++
 tb/tb_icache_sa.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_sa_if.sv
// rtl/icache_sa_if.sv - fetch and refill signal bundle for icache_sa
// The slave view belongs to the cache; the master view belongs to the fetch stage and memory side.
interface icache_sa_if #(
   parameter int LINE_WORDS = 4
);
   logic [31:0]              if_pc_i;
   logic                     if_req_i;
   logic                     flush_i;
   logic                     fence_i;
   logic [31:0]              inst_o;
   logic                     ready_o;
   logic                     hit_o;
   logic [31:0]              mem_addr_o;
   logic                     mem_valid_o;
   logic                     mem_ready_i;
   logic [32*LINE_WORDS-1:0] mem_data_i;

   modport slave (
      input  if_pc_i, if_req_i, flush_i, fence_i, mem_ready_i, mem_data_i,
      output inst_o, ready_o, hit_o, mem_addr_o, mem_valid_o
   );

   modport master (
      output if_pc_i, if_req_i, flush_i, fence_i, mem_ready_i, mem_data_i,
      input  inst_o, ready_o, hit_o, mem_addr_o, mem_valid_o
   );
endinterface

// File: rtl/icache_sa.sv
// rtl/icache_sa.sv - set-associative instruction cache with round-robin replacement
// One word per request; a miss issues a single line-wide refill that always completes.
module icache_sa #(
   parameter int WAYS       = 2,
   parameter int SETS       = 8,
   parameter int LINE_WORDS = 4
) (
   input logic        clk,
   input logic        rst_n,
   icache_sa_if.slave bus
);
   localparam int OFF_W  = $clog2(LINE_WORDS);
   localparam int IDX_W  = $clog2(SETS);
   localparam int TAG_W  = 30 - OFF_W - IDX_W;
   localparam int PTR_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int LINE_W = 32 * LINE_WORDS;

   typedef enum logic [1:0] {LOOKUP, REFILL, REFILL_KILLED} state_t;

   state_t            state_q, state_d;
   logic [WAYS-1:0]   valid_q [SETS];
   logic [PTR_W-1:0]  ptr_q   [SETS];
   logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
   logic [LINE_W-1:0] line_q  [WAYS][SETS];

   logic              fence_pend_q, fence_pend_d;
   logic [TAG_W-1:0]  miss_tag_q;
   logic [IDX_W-1:0]  miss_idx_q;
   logic [OFF_W-1:0]  miss_off_q;
   logic [PTR_W-1:0]  victim_q, victim_d;
   logic              from_ptr_q, from_ptr_d;
   logic [31:0]       inst_q, inst_d, mem_addr_q, mem_addr_d;
   logic              ready_q, ready_d, mem_valid_q, mem_valid_d;
   logic              latch_miss, fill_en, inval_all;

   logic [OFF_W-1:0]  pc_off;
   logic [IDX_W-1:0]  pc_idx;
   logic [TAG_W-1:0]  pc_tag;
   logic              hit_any, inv_any;
   logic [PTR_W-1:0]  hit_way, inv_way;

   assign pc_off = bus.if_pc_i[OFF_W+1:2];
   assign pc_idx = bus.if_pc_i[OFF_W+IDX_W+1:OFF_W+2];
   assign pc_tag = bus.if_pc_i[31:OFF_W+IDX_W+2];

   function automatic logic [31:0] word_of(input logic [LINE_W-1:0] line,
                                           input logic [OFF_W-1:0]  off);
      return line[32*int'(off) +: 32];
   endfunction

   // Descending scan so the lowest-numbered matching / invalid way wins.
   always_comb begin
      hit_any = 1'b0;
      hit_way = '0;
      inv_any = 1'b0;
      inv_way = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (valid_q[pc_idx][w] && (tag_q[w][pc_idx] == pc_tag)) begin
            hit_any = 1'b1;
            hit_way = PTR_W'(w);
         end
         if (!valid_q[pc_idx][w]) begin
            inv_any = 1'b1;
            inv_way = PTR_W'(w);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= LOOKUP;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d      = state_q;
      inst_d       = '0;
      ready_d      = 1'b0;
      mem_valid_d  = 1'b0;
      mem_addr_d   = mem_addr_q;
      victim_d     = victim_q;
      from_ptr_d   = from_ptr_q;
      fence_pend_d = fence_pend_q;
      latch_miss   = 1'b0;
      fill_en      = 1'b0;
      inval_all    = 1'b0;
      case (state_q)
         LOOKUP: begin
            inval_all = bus.fence_i;
            if (!bus.flush_i && bus.if_req_i) begin
               if (hit_any && !bus.fence_i) begin
                  inst_d  = word_of(line_q[hit_way][pc_idx], pc_off);
                  ready_d = 1'b1;
               end else begin
                  // A fence this cycle empties the set, so way 0 is the invalid-first pick.
                  latch_miss  = 1'b1;
                  victim_d    = bus.fence_i ? '0 : (inv_any ? inv_way : ptr_q[pc_idx]);
                  from_ptr_d  = !bus.fence_i && !inv_any;
                  mem_valid_d = 1'b1;
                  mem_addr_d  = {bus.if_pc_i[31:OFF_W+2], {(OFF_W+2){1'b0}}};
                  state_d     = REFILL;
               end
            end
         end
         REFILL, REFILL_KILLED: begin
            if (bus.fence_i) fence_pend_d = 1'b1;
            if (bus.mem_ready_i) begin
               fill_en = 1'b1;
               state_d = LOOKUP;
               if (state_q == REFILL && !bus.flush_i) begin
                  inst_d  = word_of(bus.mem_data_i, miss_off_q);
                  ready_d = 1'b1;
               end
               if (fence_pend_q || bus.fence_i) begin
                  inval_all    = 1'b1;
                  fence_pend_d = 1'b0;
               end
            end else if (bus.flush_i) begin
               state_d = REFILL_KILLED;
            end
         end
         default: state_d = LOOKUP;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inst_q       <= '0;
         ready_q      <= 1'b0;
         mem_valid_q  <= 1'b0;
         mem_addr_q   <= '0;
         fence_pend_q <= 1'b0;
         victim_q     <= '0;
         from_ptr_q   <= 1'b0;
         miss_tag_q   <= '0;
         miss_idx_q   <= '0;
         miss_off_q   <= '0;
      end else begin
         inst_q       <= inst_d;
         ready_q      <= ready_d;
         mem_valid_q  <= mem_valid_d;
         mem_addr_q   <= mem_addr_d;
         fence_pend_q <= fence_pend_d;
         victim_q     <= victim_d;
         from_ptr_q   <= from_ptr_d;
         if (latch_miss) begin
            miss_tag_q <= pc_tag;
            miss_idx_q <= pc_idx;
            miss_off_q <= pc_off;
         end
      end
   end

   // Invalidation wins over a same-edge fill so a fenced refill leaves nothing valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            ptr_q[s]   <= '0;
         end
      end else if (inval_all) begin
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            ptr_q[s]   <= '0;
         end
      end else if (fill_en) begin
         valid_q[miss_idx_q][victim_q] <= 1'b1;
         if (from_ptr_q)
            ptr_q[miss_idx_q] <= (ptr_q[miss_idx_q] == PTR_W'(WAYS - 1)) ? '0
                                 : ptr_q[miss_idx_q] + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (fill_en) begin
         tag_q[victim_q][miss_idx_q]  <= miss_tag_q;
         line_q[victim_q][miss_idx_q] <= bus.mem_data_i;
      end
   end

   assign bus.inst_o      = inst_q;
   assign bus.ready_o     = ready_q;
   assign bus.hit_o       = hit_any;
   assign bus.mem_addr_o  = mem_addr_q;
   assign bus.mem_valid_o = mem_valid_q;
endmodule

// File: tb/tb_icache_sa.sv
// tb/tb_icache_sa.sv - directed and randomized checks of icache_sa in three configurations
// Instance 0 uses default parameters; instances 1 and 2 cover the parameter sweep.
module tb_icache_sa;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int sel     = 0;

   logic [31:0]  sw_pc     = '0;
   logic         sw_req    = 1'b0;
   logic         sw_flush  = 1'b0;
   logic         sw_fence  = 1'b0;
   logic         sw_mready = 1'b0;
   logic         use_dline = 1'b0;
   logic [127:0] dline     = '0;

   icache_sa_if #(.LINE_WORDS(4)) b0 ();
   icache_sa_if #(.LINE_WORDS(2)) b1 ();
   icache_sa_if #(.LINE_WORDS(8)) b2 ();

   icache_sa #(.WAYS(2), .SETS(8),  .LINE_WORDS(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
   icache_sa #(.WAYS(1), .SETS(16), .LINE_WORDS(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
   icache_sa #(.WAYS(4), .SETS(4),  .LINE_WORDS(8)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));

   assign b0.if_pc_i     = sw_pc;
   assign b0.if_req_i    = sw_req    && (sel == 0);
   assign b0.flush_i     = sw_flush  && (sel == 0);
   assign b0.fence_i     = sw_fence  && (sel == 0);
   assign b0.mem_ready_i = sw_mready && (sel == 0);
   assign b1.if_pc_i     = sw_pc;
   assign b1.if_req_i    = sw_req    && (sel == 1);
   assign b1.flush_i     = sw_flush  && (sel == 1);
   assign b1.fence_i     = sw_fence  && (sel == 1);
   assign b1.mem_ready_i = sw_mready && (sel == 1);
   assign b2.if_pc_i     = sw_pc;
   assign b2.if_req_i    = sw_req    && (sel == 2);
   assign b2.flush_i     = sw_flush  && (sel == 2);
   assign b2.fence_i     = sw_fence  && (sel == 2);
   assign b2.mem_ready_i = sw_mready && (sel == 2);

   // Reference memory: every word is a fixed hash of its byte address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] w;
      w = {a[31:2], 2'b00};
      return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   logic [127:0] line0;
   logic [63:0]  line1;
   logic [255:0] line2;
   always_comb begin
      line0 = '0;
      for (int k = 0; k < 4; k++) line0[32*k +: 32] = mem_word(b0.mem_addr_o + 32'(4*k));
   end
   always_comb begin
      line1 = '0;
      for (int k = 0; k < 2; k++) line1[32*k +: 32] = mem_word(b1.mem_addr_o + 32'(4*k));
   end
   always_comb begin
      line2 = '0;
      for (int k = 0; k < 8; k++) line2[32*k +: 32] = mem_word(b2.mem_addr_o + 32'(4*k));
   end
   assign b0.mem_data_i = use_dline ? dline : line0;
   assign b1.mem_data_i = line1;
   assign b2.mem_data_i = line2;

   logic [31:0] o_inst, o_maddr;
   logic        o_ready, o_hit, o_mvalid;
   always_comb begin
      case (sel)
         1: begin
            o_inst = b1.inst_o; o_maddr = b1.mem_addr_o; o_ready = b1.ready_o;
            o_hit = b1.hit_o; o_mvalid = b1.mem_valid_o;
         end
         2: begin
            o_inst = b2.inst_o; o_maddr = b2.mem_addr_o; o_ready = b2.ready_o;
            o_hit = b2.hit_o; o_mvalid = b2.mem_valid_o;
         end
         default: begin
            o_inst = b0.inst_o; o_maddr = b0.mem_addr_o; o_ready = b0.ready_o;
            o_hit = b0.hit_o; o_mvalid = b0.mem_valid_o;
         end
      endcase
   end

   // Behavioural cache model: which line addresses each set holds, and the replacement pointer.
   int          cfg_ways [3] = '{2, 1, 4};
   int          cfg_sets [3] = '{8, 16, 4};
   int          cfg_offw [3] = '{2, 1, 3};
   bit          mval  [3][4][16];
   int unsigned mline [3][4][16];
   int          mptr  [3][16];

   function automatic void model_clear(input int s);
      for (int w = 0; w < 4; w++)
         for (int i = 0; i < 16; i++) mval[s][w][i] = 1'b0;
      for (int i = 0; i < 16; i++) mptr[s][i] = 0;
   endfunction

   function automatic bit model_hit(input int s, input logic [31:0] pc);
      int unsigned la = pc >> (2 + cfg_offw[s]);
      int          ix = int'(la % cfg_sets[s]);
      for (int w = 0; w < cfg_ways[s]; w++)
         if (mval[s][w][ix] && mline[s][w][ix] == la) return 1'b1;
      return 1'b0;
   endfunction

   function automatic void model_fill(input int s, input logic [31:0] pc);
      int unsigned la = pc >> (2 + cfg_offw[s]);
      int          ix = int'(la % cfg_sets[s]);
      int          v  = -1;
      for (int w = 0; w < cfg_ways[s]; w++)
         if (!mval[s][w][ix] && v < 0) v = w;
      if (v < 0) begin
         v = mptr[s][ix];
         mptr[s][ix] = (mptr[s][ix] + 1) % cfg_ways[s];
      end
      mval[s][v][ix]  = 1'b1;
      mline[s][v][ix] = la;
   endfunction

   function automatic logic [31:0] line_base(input logic [31:0] pc);
      return pc & ~((32'd4 << cfg_offw[sel]) - 32'd1);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic fence_pulse;
      sw_fence = 1'b1;
      tick();
      sw_fence = 1'b0;
   endtask

   task automatic request(input logic [31:0] pc);
      sw_pc  = pc;
      sw_req = 1'b1;
      tick();
      sw_req = 1'b0;
   endtask

   task automatic fill(input logic with_flush);
      sw_mready = 1'b1;
      sw_flush  = with_flush;
      tick();
      sw_mready = 1'b0;
      sw_flush  = 1'b0;
   endtask

   task automatic check_hit(input string tag, input logic [31:0] pc, input logic exp);
      sw_pc = pc;
      #1;
      check(tag, 32'(o_hit), 32'(exp));
   endtask

   task automatic expect_hit(input string tag, input logic [31:0] pc);
      request(pc);
      check({tag, "_rdy"}, 32'(o_ready), 32'd1);
      check({tag, "_inst"}, o_inst, mem_word(pc));
      check({tag, "_mvalid"}, 32'(o_mvalid), 32'd0);
   endtask

   task automatic expect_miss(input string tag, input logic [31:0] pc);
      request(pc);
      check({tag, "_mvalid"}, 32'(o_mvalid), 32'd1);
      check({tag, "_maddr"}, o_maddr, line_base(pc));
      check({tag, "_rdy0"}, 32'(o_ready), 32'd0);
      tick();
      check({tag, "_pulse"}, 32'(o_mvalid), 32'd0);
      fill(1'b0);
      check({tag, "_rdy"}, 32'(o_ready), 32'd1);
      check({tag, "_inst"}, o_inst, mem_word(pc));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] pc;
      bit          eh;
      int          pulses;

      rst_n = 1'b0;
      repeat (3) tick();
      check("rst_ready", 32'(o_ready), 32'd0);
      check("rst_inst", o_inst, 32'd0);
      check("rst_mvalid", 32'(o_mvalid), 32'd0);
      check("rst_maddr", o_maddr, 32'd0);
      check_hit("rst_hit", 32'h0000_0100, 1'b0);
      rst_n = 1'b1;
      tick();

      // Cold miss with explicit line contents, then back-to-back hits.
      use_dline = 1'b1;
      dline = {32'hD, 32'hC, 32'hB, 32'hA};
      request(32'h100);
      check("cold_mvalid", 32'(o_mvalid), 32'd1);
      check("cold_maddr", o_maddr, 32'h100);
      check("cold_rdy0", 32'(o_ready), 32'd0);
      tick();
      check("cold_pulse", 32'(o_mvalid), 32'd0);
      fill(1'b0);
      check("cold_rdy", 32'(o_ready), 32'd1);
      check("cold_inst", o_inst, 32'hA);
      check_hit("cold_hit10c", 32'h10C, 1'b1);
      sw_req = 1'b1;
      tick();
      check("b2b_rdy0", 32'(o_ready), 32'd1);
      check("b2b_inst0", o_inst, 32'hD);
      check("b2b_mvalid", 32'(o_mvalid), 32'd0);
      sw_pc = 32'h104;
      tick();
      check("b2b_rdy1", 32'(o_ready), 32'd1);
      check("b2b_inst1", o_inst, 32'hB);
      sw_req = 1'b0;
      tick();
      check("idle_rdy", 32'(o_ready), 32'd0);
      check("idle_inst", o_inst, 32'd0);
      use_dline = 1'b0;

      // Conflict in set 0: invalid-first, then round-robin.
      fence_pulse();
      check_hit("fence_hit100", 32'h100, 1'b0);
      expect_miss("cf_000", 32'h000);
      expect_miss("cf_080", 32'h080);
      check_hit("cf_hit000", 32'h000, 1'b1);
      check_hit("cf_hit080", 32'h080, 1'b1);
      expect_miss("cf_100", 32'h100);
      check_hit("cf_evict000", 32'h000, 1'b0);
      check_hit("cf_keep080", 32'h080, 1'b1);
      expect_hit("cf_hit080r", 32'h080);
      expect_miss("cf_000b", 32'h000);
      check_hit("cf_evict080", 32'h080, 1'b0);
      check_hit("cf_keep100", 32'h100, 1'b1);

      // Kill during refill.
      request(32'h200);
      check("kill_mvalid", 32'(o_mvalid), 32'd1);
      tick();
      sw_flush = 1'b1;
      tick();
      sw_flush = 1'b0;
      check("kill_rdy0", 32'(o_ready), 32'd0);
      fill(1'b0);
      check("kill_rdy", 32'(o_ready), 32'd0);
      tick();
      check("kill_rdy2", 32'(o_ready), 32'd0);
      expect_hit("kill_after", 32'h200);

      // Flush in the same cycle as the fill data.
      request(32'h240);
      check("sim_mvalid", 32'(o_mvalid), 32'd1);
      tick();
      fill(1'b1);
      check("sim_rdy", 32'(o_ready), 32'd0);
      check("sim_inst", o_inst, 32'd0);
      check_hit("sim_hit", 32'h240, 1'b1);
      expect_hit("sim_after", 32'h240);

      // Fence while a refill is outstanding.
      request(32'h300);
      fence_pulse();
      tick();
      fill(1'b0);
      check("fr_rdy", 32'(o_ready), 32'd1);
      check("fr_inst", o_inst, mem_word(32'h300));
      check_hit("fr_hit300", 32'h300, 1'b0);
      check_hit("fr_hit200", 32'h200, 1'b0);
      check_hit("fr_hit240", 32'h240, 1'b0);
      expect_miss("fr_300", 32'h300);

      // Fence in the same cycle as the fill data.
      request(32'h340);
      sw_fence = 1'b1;
      fill(1'b0);
      sw_fence = 1'b0;
      check("ff_rdy", 32'(o_ready), 32'd1);
      check_hit("ff_hit340", 32'h340, 1'b0);
      check_hit("ff_hit300", 32'h300, 1'b0);

      // Fence alongside a request for a cached line: treated as a miss.
      expect_miss("fl_300", 32'h300);
      sw_fence = 1'b1;
      request(32'h300);
      sw_fence = 1'b0;
      check("fl_mvalid", 32'(o_mvalid), 32'd1);
      check("fl_rdy0", 32'(o_ready), 32'd0);
      tick();
      fill(1'b0);
      check("fl_rdy", 32'(o_ready), 32'd1);
      check_hit("fl_hit300", 32'h300, 1'b1);

      // Reset in the middle of a refill.
      request(32'h400);
      check("rr_mvalid", 32'(o_mvalid), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rr_mvalid0", 32'(o_mvalid), 32'd0);
      check("rr_maddr", o_maddr, 32'd0);
      check_hit("rr_hit300", 32'h300, 1'b0);
      tick();
      rst_n = 1'b1;
      fill(1'b0);
      check("rr_rdy", 32'(o_ready), 32'd0);
      expect_miss("rr_400", 32'h400);

      // Random address stream per configuration against the reference memory and model.
      for (int s = 0; s < 3; s++) begin
         sel = s;
         tick();
         fence_pulse();
         model_clear(s);
         for (int i = 0; i < 200; i++) begin
            pc = (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 63)) << 2);
            eh = model_hit(s, pc);
            check_hit("rnd_hit", pc, eh);
            request(pc);
            if (eh) begin
               check("rnd_hrdy", 32'(o_ready), 32'd1);
               check("rnd_hinst", o_inst, mem_word(pc));
               check("rnd_hmv", 32'(o_mvalid), 32'd0);
            end else begin
               check("rnd_mv", 32'(o_mvalid), 32'd1);
               check("rnd_maddr", o_maddr, line_base(pc));
               pulses = 0;
               repeat ($urandom_range(1, 4)) begin
                  tick();
                  if (o_mvalid) pulses++;
               end
               check("rnd_pulses", 32'(pulses), 32'd0);
               fill(1'b0);
               check("rnd_mrdy", 32'(o_ready), 32'd1);
               check("rnd_minst", o_inst, mem_word(pc));
               model_fill(s, pc);
            end
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
